// File: rtl/pipe_ctrl_unit_pkg.sv
// pipe_ctrl_unit_pkg: stage indices, hold-FSM state encodings and stage-mask helper shared by the stall controller.
package pipe_ctrl_unit_pkg;
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  // stage j belongs to the mask of a stage-k requester; the last stage (WB) is never held or flushed
  function automatic logic stage_in(int j, int k, int n);
    return j <= k && j != n - 1;
  endfunction
endpackage

// File: rtl/pipe_mc_hold.sv
// pipe_mc_hold: IDLE/BUSY/DONE sequencer for multi-cycle ops; holds the pipe while BUSY, pulses done in DONE.
module pipe_mc_hold
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cycles,
  output logic             hold,
  output logic             done
);
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (abort) state_d = S_IDLE;
    else if (state_q == S_IDLE && start) begin
      state_d = cycles != '0 ? S_BUSY : S_DONE;
      cnt_d = cycles;
    end else if (state_q == S_BUSY) begin
      cnt_d = cnt_q - 1'b1;
      state_d = cnt_q == CNT_W'(1) ? S_DONE : S_BUSY;
    end else if (state_q == S_DONE) state_d = S_IDLE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign hold = state_q == S_BUSY;
  assign done = state_q == S_DONE;
endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: merges stall, multi-cycle hold and flush requests into per-stage stall/flush vectors,
// registers the pc redirect and counts stalled cycles.
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int                   NUM_STAGES  = 6,
  parameter int                   NUM_SRC     = 2,
  parameter logic [3*NUM_SRC-1:0] SRC_STAGE   = {3'd3, 3'd2},
  parameter int                   MC_STAGE    = STG_EX,
  parameter int                   FLUSH_STAGE = STG_EX,
  parameter int                   CNT_W       = 6
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_SRC-1:0]    stallreq,
  input  logic                  mc_start,
  input  logic [CNT_W-1:0]      mc_cycles,
  output logic                  mc_done,
  input  logic                  flush_req,
  input  logic [31:0]           flush_pc,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  redirect_vld,
  output logic [31:0]           redirect_pc,
  output logic [31:0]           stall_cycles
);
  logic mc_hold;
  logic [NUM_SRC-1:0][NUM_STAGES-1:0] src_mask;
  logic [NUM_STAGES-1:0] mc_mask, fl_mask, fl_clr, req_stall;
  logic redirect_vld_q, redirect_vld_d;
  logic [31:0] redirect_pc_q, redirect_pc_d, stall_cycles_q, stall_cycles_d;
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    for (genvar j = 0; j < NUM_STAGES; j++) begin : g_bit
      assign src_mask[s][j] = stallreq[s] && stage_in(j, int'(SRC_STAGE[3*s+:3]), NUM_STAGES);
    end
  end
  for (genvar j = 0; j < NUM_STAGES; j++) begin : g_stage
    assign mc_mask[j] = stage_in(j, MC_STAGE, NUM_STAGES);
    assign fl_mask[j] = j > 0 && stage_in(j, FLUSH_STAGE, NUM_STAGES);
    assign fl_clr[j] = j <= FLUSH_STAGE;
  end
  always_comb begin
    req_stall = mc_hold ? mc_mask : '0;
    for (int s = 0; s < NUM_SRC; s++) req_stall |= src_mask[s];
  end
  // a flush squashes the holds it would otherwise fight with; stages past the resolver keep their stalls
  assign stall = flush_req ? req_stall & ~fl_clr : req_stall;
  assign flush = flush_req ? fl_mask : '0;
  pipe_mc_hold #(.CNT_W(CNT_W)) u_mc_hold (
    .clk(clk),
    .resetn(resetn),
    .start(mc_start && !flush_req),
    .abort(flush_req),
    .cycles(mc_cycles),
    .hold(mc_hold),
    .done(mc_done)
  );
  always_comb begin
    redirect_vld_d = flush_req;
    redirect_pc_d = flush_req ? flush_pc : redirect_pc_q;
    stall_cycles_d = stall_cycles_q + 32'(stall[0]);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      redirect_vld_q <= 1'b0;
      redirect_pc_q <= '0;
      stall_cycles_q <= '0;
    end else begin
      redirect_vld_q <= redirect_vld_d;
      redirect_pc_q <= redirect_pc_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
  assign redirect_vld = redirect_vld_q;
  assign redirect_pc = redirect_pc_q;
  assign stall_cycles = stall_cycles_q;
endmodule
